// File: rtl/rv_pkg.sv
// rv_pkg: RV32 opcode constants shared with the control unit, instruction
// field slice positions, the fetch-entry type and the J-immediate helper.
package rv_pkg;

  localparam logic [6:0] Rtype  = 7'b0110011;
  localparam logic [6:0] Itype  = 7'b0010011;
  localparam logic [6:0] sw     = 7'b0100011;
  localparam logic [6:0] lw     = 7'b0000011;
  localparam logic [6:0] sbtype = 7'b1100011;
  localparam logic [6:0] ujtype = 7'b1101111;
  localparam logic [6:0] Ijtype = 7'b1100111;
  localparam logic [6:0] luI    = 7'b0110111;

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int RD_LSB  = 7;
  localparam int RD_MSB  = 11;
  localparam int F3_LSB  = 12;
  localparam int F3_MSB  = 14;
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;
  localparam int F7_LSB  = 25;
  localparam int F7_MSB  = 31;

  // Widest PC an entry can carry; fetch units use ADDR_W <= PC_W.
  localparam int PC_W = 32;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic            jumpTaken;
  } fetch_entry_t;

  // Sign-extended J-type immediate (jal offset).
  function automatic logic [31:0] j_imm(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries with flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  output fetch_entry_t rdata,
  output logic         empty,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign rdata   = mem[rptr];
  assign do_pop  = pop && !empty;
  // A push at full is legal only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy update; flush drops everything, including a same-cycle push/pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !(reset || flush)) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC holder, in-order imem requester and decode-side buffer.
// Optional macro FETCH_PREDECODE_EN: jal words redirect fetch internally and
// are marked with dec_jumpTaken; without it dec_jumpTaken is tied 0.
module instr_fetch_unit
  import rv_pkg::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter int                 DEPTH    = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [ADDR_W-1:0] dec_pc,
  output logic [31:0]       dec_instr,
  output logic [6:0]        dec_opCode,
  output logic [2:0]        dec_funct3,
  output logic [6:0]        dec_funct7,
  output logic [4:0]        dec_rd,
  output logic [4:0]        dec_rs1,
  output logic [4:0]        dec_rs2,
  output logic              dec_jumpTaken
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] pc, rsp_pc, pd_tgt, redir_tgt;
  logic [CW-1:0]     outstanding, drop_cnt, fifo_count;
  logic [CW:0]       credit_used;
  logic              accept, rsp_keep, pd_jal, redir, fifo_empty;
  fetch_entry_t      push_e, head_raw, head;

  // Words in flight plus words buffered never exceed DEPTH, so every kept response has a slot.
  assign credit_used    = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid = !reset && !redir && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && (drop_cnt == '0);

`ifdef FETCH_PREDECODE_EN
  assign pd_jal = rsp_keep && (imem_rsp_data[OPC_MSB:OPC_LSB] == ujtype);
  assign pd_tgt = rsp_pc + ADDR_W'(j_imm(imem_rsp_data));
`else
  assign pd_jal = 1'b0;
  assign pd_tgt = '0;
`endif

  // External redirect outranks a predecoded jal in the same cycle.
  assign redir     = redirect_valid || pd_jal;
  assign redir_tgt = redirect_valid ? redirect_pc : pd_tgt;

  // Entry pushed for a kept response; jumpTaken marks a predecoded jal.
  always_comb begin
    push_e                = '0;
    push_e.pc[ADDR_W-1:0] = rsp_pc;
    push_e.instr          = imem_rsp_data;
    push_e.jumpTaken      = pd_jal && !redirect_valid;
  end

  // PC, response PC, in-flight count and drop count.
  // On redirect no request is issued, so only a same-cycle response retires;
  // every other in-flight word belongs to the abandoned path and is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redir) begin
      pc          <= redir_tgt;
      rsp_pc      <= redir_tgt;
      outstanding <= outstanding - CW'(imem_rsp_valid);
      drop_cnt    <= outstanding - CW'(imem_rsp_valid);
    end else begin
      if (accept) pc <= pc + ADDR_W'(4);
      outstanding <= outstanding + CW'(accept) - CW'(imem_rsp_valid);
      if (imem_rsp_valid) begin
        if (drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        else                rsp_pc   <= rsp_pc + ADDR_W'(4);
      end
    end
  end

  // Only an external redirect flushes: entries ahead of a predecoded jal are older and stay.
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (rsp_keep && !redirect_valid),
    .wdata (push_e),
    .pop   (dec_valid && dec_ready),
    .rdata (head_raw),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Present zeros when nothing is buffered so idle outputs never show stale storage.
  always_comb begin
    head = head_raw;
    if (fifo_empty) head = '0;
  end

  assign dec_valid     = !fifo_empty;
  assign dec_pc        = head.pc[ADDR_W-1:0];
  assign dec_instr     = head.instr;
  assign dec_opCode    = head.instr[OPC_MSB:OPC_LSB];
  assign dec_funct3    = head.instr[F3_MSB:F3_LSB];
  assign dec_funct7    = head.instr[F7_MSB:F7_LSB];
  assign dec_rd        = head.instr[RD_MSB:RD_LSB];
  assign dec_rs1       = head.instr[RS1_MSB:RS1_LSB];
  assign dec_rs2       = head.instr[RS2_MSB:RS2_LSB];
  assign dec_jumpTaken = head.jumpTaken;

endmodule
